psum_spad_ctrl: RTL
===================

// Module: psum_spad_ctrl
// PURPOSE
//  Initiator side of the PE psum scratchpad port; owns w_en/w_addr/din/r_addr and consumes dout.
//  Accumulates a product stream into MEM_DEPTH psum entries over num_pass passes, then drains the entries in order.
//  Sits between the PE MAC datapath (upstream) and the PE psum output FIFO (downstream).
// PARAMETERS
//  MEM_DEPTH   24                 psum entries in the scratchpad
//  DATA_WIDTH  16                 psum and product width, two's complement
//  ADDR_WIDTH  $clog2(MEM_DEPTH)  scratchpad address width
//  PASS_WIDTH  8                  width of the pass counter
// PORTS
//  clk        in   1           single clock; this block and the scratchpad are both clocked by it
//  rst        in   1           synchronous, active-high reset
//  start      in   1           one-cycle pulse; sampled in IDLE only
//  num_psum   in   ADDR_WIDTH  entries per pass (0..MEM_DEPTH); latched on start
//  num_pass   in   PASS_WIDTH  accumulation passes; latched on start; 0 is treated as 1
//  in_valid   in   1           product valid
//  in_ready   out  1           product accepted when in_valid & in_ready
//  in_data    in   DATA_WIDTH  product
//  out_valid  out  1           drained psum valid
//  out_ready  in   1           downstream accepts the psum
//  out_data   out  DATA_WIDTH  drained psum
//  busy       out  1           high whenever state != IDLE
//  done       out  1           one-cycle pulse at end of drain
//  sp_w_en    out  1           scratchpad write enable
//  sp_w_addr  out  ADDR_WIDTH  scratchpad write address
//  sp_din     out  DATA_WIDTH  scratchpad write data
//  sp_r_addr  out  ADDR_WIDTH  scratchpad read address
//  sp_dout    in   DATA_WIDTH  scratchpad read data
// BEHAVIOUR
//  Scratchpad timing:
//   - Scratchpad writes and reads on negedge clk; all sp_* outputs are registered on posedge.
//   - r_addr driven at posedge N gives sp_dout that is valid at posedge N+1.
//   - A same-negedge write and read to one address returns the OLD data.
//  Reset: state=IDLE. in_ready, out_valid, out_data, busy, done, sp_w_en, sp_w_addr, sp_din, sp_r_addr all 0.
//   - Reset mid-operation aborts immediately. Scratchpad contents are left undefined; no clear is performed.
//  FSM:
//   - IDLE -> ACCUM on start.
//   - ACCUM -> DRAIN_RD after the final write of the last pass.
//   - DRAIN_RD -> DRAIN_OUT.
//   - DRAIN_OUT -> DRAIN_RD on handshake while entries remain; -> DONE after the last entry.
//   - DONE -> IDLE, with done=1 for that single cycle.
//   - num_psum==0: start -> DONE -> IDLE. No product is accepted and no scratchpad access is made.
//  ACCUM pipeline (2 stages, 1 product/cycle):
//   - S1: on accept, sp_r_addr <= idx, where idx is the entry counter. idx wraps from num_psum-1 to 0 and the pass counter increments.
//   - S2 (next cycle): sum = operand + product. sp_w_en=1, sp_w_addr=idx, sp_din=sum.
//   - Pass 0: operand = 0; the old contents are never read.
//   - Later passes: operand = sp_dout.
//   - Forwarding: if the S2 address equals the address being written in the same cycle, operand = that cycle's sp_din. This covers num_psum==1 back-to-back.
//   - sp_w_en is low in every cycle without an S2 write. Bubbles on in_valid insert no extra latency.
//   - in_ready=1 in ACCUM until the last product of the last pass is accepted; 0 otherwise.
//  Arithmetic: DATA_WIDTH signed add, wrapping modulo 2^DATA_WIDTH (see CONFIGURATION for the alternative).
//  Drain:
//   - DRAIN_RD drives sp_r_addr=k.
//   - DRAIN_OUT latches out_data=sp_dout and raises out_valid.
//   - out_valid and out_data hold stable until out_ready. The handshake drops out_valid the next cycle.
//   - Entries drain in order 0..num_psum-1; peak rate is 1 entry per 2 cycles.
//  start outside IDLE is ignored. in_data is ignored whenever in_ready=0.
// CONFIGURATION
//  PSUM_SAT_EN defined:
//   - The accumulate add saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Overflow is detected from the operand/result sign bits.
//   - The saturated value is also the value forwarded.
//  PSUM_SAT_EN undefined: wrapping add; no saturation logic is synthesised.
// TESTING
//  T1 num_psum=3, num_pass=2, products 1,2,3,10,20,30 streamed back-to-back -> out_data 11,22,33; then done=1 for 1 cycle.
//  T2 num_psum=1, num_pass=4, products 5,5,5,5 every cycle -> out 20 (forwarding exercised); no bubble on in_ready.
//  T3 out_ready held 0 for 5 cycles on entry 0 -> out_valid/out_data stable; then out_ready=1 -> next entry follows.
//  T4 rst asserted in ACCUM mid-pass 1 -> next cycle all outputs 0, busy=0; a fresh start runs T1 correctly.
//  T5 num_psum=0, start -> done pulses 2 cycles later; sp_w_en never asserted; in_ready stays 0.
//  T6 DATA_WIDTH=16, products 0x7FFF then 0x0001 over 2 passes -> 0x8000 without PSUM_SAT_EN, 0x7FFF with it.

Source files
------------

// File: rtl/psum_spad_ctrl.sv
// -----------------------------------------------------------------------------
// psum_spad_ctrl
//   Initiator side of the PE psum scratchpad port. This block accumulates a
//   stream of products into num_psum scratchpad entries over num_pass passes.
//   After the last pass it drains the entries in order to the psum output FIFO.
//
//   Build option:
//     PSUM_SAT_EN - when defined, the accumulate add saturates instead of
//                   wrapping. When undefined, a plain wrapping add is used.
//
//   Ports:
//     clk, rst              clock; synchronous active-high reset
//     start                 one-cycle job start, sampled in IDLE only
//     num_psum, num_pass    job shape, latched on start (num_pass 0 acts as 1)
//     in_valid/in_ready/in_data     product stream from the MAC datapath
//     out_valid/out_ready/out_data  drained psums to the output FIFO
//     busy, done            status; done pulses for one cycle at end of drain
//     sp_w_en, sp_w_addr, sp_din    scratchpad write port (registered)
//     sp_r_addr, sp_dout            scratchpad read port (address registered)
//
//   The scratchpad reads and writes on negedge clk. An address driven at
//   posedge N returns data on sp_dout at posedge N+1.
// -----------------------------------------------------------------------------
module psum_spad_ctrl #(
    parameter int MEM_DEPTH  = 24,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int PASS_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] num_psum,
    input  logic [PASS_WIDTH-1:0] num_pass,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  done,
    output logic                  sp_w_en,
    output logic [ADDR_WIDTH-1:0] sp_w_addr,
    output logic [DATA_WIDTH-1:0] sp_din,
    output logic [ADDR_WIDTH-1:0] sp_r_addr,
    input  logic [DATA_WIDTH-1:0] sp_dout
);

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DRAIN_RD,
        DRAIN_OUT,
        DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_num_psum;
    logic [PASS_WIDTH-1:0] r_num_pass;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [PASS_WIDTH-1:0] r_pass;
    logic [ADDR_WIDTH-1:0] r_k;
    logic                  r_in_ready;

    // Stage-1 holding registers (product accepted, read in flight)
    logic                  r_s1_vld;
    logic [ADDR_WIDTH-1:0] r_s1_idx;
    logic [DATA_WIDTH-1:0] r_s1_data;
    logic                  r_s1_first;
    logic                  r_s1_last;
    // Set while the final write of the job is being performed
    logic                  r_wr_last;

    logic                  r_sp_w_en;
    logic [ADDR_WIDTH-1:0] r_sp_w_addr;
    logic [DATA_WIDTH-1:0] r_sp_din;
    logic [ADDR_WIDTH-1:0] r_sp_r_addr;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;

    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_last_idx;
    logic                  w_idx_wrap;
    logic                  w_pass_last;
    logic                  w_fwd;
    logic [DATA_WIDTH-1:0] w_operand;
    logic [DATA_WIDTH-1:0] w_sum_raw;
    logic [DATA_WIDTH-1:0] w_sum;
    logic                  w_drain_hs;
    logic                  w_drain_last;

    assign w_accept     = in_valid & r_in_ready;
    assign w_last_idx   = r_num_psum - ADDR_WIDTH'(1);
    assign w_idx_wrap   = (r_idx == w_last_idx);
    assign w_pass_last  = (r_pass == r_num_pass - PASS_WIDTH'(1));
    assign w_drain_hs   = r_out_valid & out_ready;
    assign w_drain_last = (r_k == w_last_idx);

    // The write issued in the previous cycle lands on the same negedge as the
    // read for this entry, so the read returns stale data; take the write data.
    assign w_fwd     = r_sp_w_en && (r_sp_w_addr == r_s1_idx);
    assign w_operand = r_s1_first ? '0 : (w_fwd ? r_sp_din : sp_dout);
    assign w_sum_raw = w_operand + r_s1_data;

`ifdef PSUM_SAT_EN
    logic w_ovf;
    // Overflow only when both addends share a sign and the result flips it
    assign w_ovf = (w_operand[DATA_WIDTH-1] == r_s1_data[DATA_WIDTH-1]) &&
                   (w_sum_raw[DATA_WIDTH-1] != w_operand[DATA_WIDTH-1]);
    assign w_sum = !w_ovf ? w_sum_raw :
                   (w_operand[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                            : {1'b0, {(DATA_WIDTH-1){1'b1}}});
`else
    assign w_sum = w_sum_raw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (num_psum == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (r_wr_last) begin
                    w_state_nxt = DRAIN_RD;
                end
            end
            DRAIN_RD: begin
                w_state_nxt = DRAIN_OUT;
            end
            DRAIN_OUT: begin
                if (w_drain_hs) begin
                    w_state_nxt = w_drain_last ? DONE : DRAIN_RD;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_num_psum  <= '0;
            r_num_pass  <= '0;
            r_idx       <= '0;
            r_pass      <= '0;
            r_k         <= '0;
            r_in_ready  <= 1'b0;
            r_s1_vld    <= 1'b0;
            r_s1_idx    <= '0;
            r_s1_data   <= '0;
            r_s1_first  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_wr_last   <= 1'b0;
            r_sp_w_en   <= 1'b0;
            r_sp_w_addr <= '0;
            r_sp_din    <= '0;
            r_sp_r_addr <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            // Stage 1: issue the read for the accepted product
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_idx    <= r_idx;
                r_s1_data   <= in_data;
                r_s1_first  <= (r_pass == '0);
                r_s1_last   <= w_idx_wrap && w_pass_last;
                r_sp_r_addr <= r_idx;
                if (w_idx_wrap) begin
                    r_idx  <= '0;
                    r_pass <= r_pass + PASS_WIDTH'(1);
                    if (w_pass_last) begin
                        r_in_ready <= 1'b0;
                    end
                end else begin
                    r_idx <= r_idx + ADDR_WIDTH'(1);
                end
            end

            // Stage 2: write back the accumulated value
            r_sp_w_en <= r_s1_vld;
            r_wr_last <= r_s1_vld & r_s1_last;
            if (r_s1_vld) begin
                r_sp_w_addr <= r_s1_idx;
                r_sp_din    <= w_sum;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_num_psum <= num_psum;
                        r_num_pass <= (num_pass == '0) ? PASS_WIDTH'(1) : num_pass;
                        r_idx      <= '0;
                        r_pass     <= '0;
                        r_k        <= '0;
                        r_in_ready <= (num_psum != '0);
                    end
                end
                ACCUM: begin
                    // Read entry 0 only after the final write has landed
                    if (r_wr_last) begin
                        r_sp_r_addr <= '0;
                        r_k         <= '0;
                    end
                end
                DRAIN_RD: begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= sp_dout;
                end
                DRAIN_OUT: begin
                    if (w_drain_hs) begin
                        r_out_valid <= 1'b0;
                        if (!w_drain_last) begin
                            r_k         <= r_k + ADDR_WIDTH'(1);
                            r_sp_r_addr <= r_k + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign sp_w_en   = r_sp_w_en;
    assign sp_w_addr = r_sp_w_addr;
    assign sp_din    = r_sp_din;
    assign sp_r_addr = r_sp_r_addr;

endmodule
